// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates instruction fetches and load/store requests onto an 8-bit synchronous RAM port.
// Optional build macro MEM_CTRL_IO_STALL_EN: hold IO-address store bytes while the IO write buffer is full.
//
// state  | meaning
// IDLE   | no access in flight; requests accepted when no done pulse is showing
// IFETCH | reading FETCH_BYTES instruction bytes from pc
// LOAD   | reading lsb_len data bytes from the latched address
// STORE  | writing lsb_len data bytes, one byte per cycle
module mem_ctrl #(
   parameter int FETCH_BYTES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        rollback,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full,
   input  logic        if_en,
   input  logic [31:0] if_pc,
   output logic        if_done,
   output logic [31:0] if_data,
   input  logic        lsb_en,
   input  logic        lsb_wr,
   input  logic [31:0] lsb_addr,
   input  logic [2:0]  lsb_len,
   input  logic [31:0] lsb_w_data,
   output logic        lsb_done,
   output logic [31:0] lsb_r_data
);

   typedef enum logic [1:0] {IDLE, IFETCH, LOAD, STORE} state_t;

   localparam logic [2:0] FETCH_LEN = 3'(FETCH_BYTES);

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [2:0]  len_q, len_d;
   logic [31:0] base_q, base_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] buf_q, buf_d;
   logic        if_done_q, if_done_d;
   logic        lsb_done_q, lsb_done_d;
   logic [31:0] if_data_q, if_data_d;
   logic [31:0] lsb_r_data_q, lsb_r_data_d;

   logic [31:0] addr_cur;
   logic [2:0]  cnt_prev;
   logic        io_stall;
   logic        reading;

   assign addr_cur = base_q + {29'd0, cnt_q};
   assign cnt_prev = cnt_q - 3'd1;
   assign reading  = (state_q == IFETCH) || (state_q == LOAD);

`ifdef MEM_CTRL_IO_STALL_EN
   assign io_stall = (addr_cur[17:16] == 2'b11) && io_buffer_full;
`else
   assign io_stall = 1'b0 & io_buffer_full;
`endif

   assign if_done    = if_done_q;
   assign if_data    = if_data_q;
   assign lsb_done   = lsb_done_q;
   assign lsb_r_data = lsb_r_data_q;

   // While frozen mid-read, re-present the previous byte address so a free-running
   // RAM still returns the byte that is due to be sampled when rdy comes back.
   always_comb begin
      mem_a = addr_cur;
      if (!rdy && reading && (cnt_q != 3'd0)) begin
         mem_a = base_q + {29'd0, cnt_prev};
      end
      mem_wr = rdy && (state_q == STORE) && !io_stall;
      case (cnt_q[1:0])
         2'd0:    mem_dout = wdata_q[7:0];
         2'd1:    mem_dout = wdata_q[15:8];
         2'd2:    mem_dout = wdata_q[23:16];
         default: mem_dout = wdata_q[31:24];
      endcase
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      len_d        = len_q;
      base_d       = base_q;
      wdata_d      = wdata_q;
      buf_d        = buf_q;
      if_done_d    = if_done_q;
      lsb_done_d   = lsb_done_q;
      if_data_d    = if_data_q;
      lsb_r_data_d = lsb_r_data_q;
      if (rdy) begin
         if_done_d  = 1'b0;
         lsb_done_d = 1'b0;
         unique case (state_q)
            IDLE: begin
               if (!if_done_q && !lsb_done_q) begin
                  // a store is never squashed by rollback; loads and fetches are
                  if (lsb_en && (lsb_wr || !rollback)) begin
                     state_d = lsb_wr ? STORE : LOAD;
                     cnt_d   = 3'd0;
                     len_d   = lsb_len;
                     base_d  = lsb_addr;
                     wdata_d = lsb_w_data;
                     buf_d   = '0;
                  end else if (if_en && !rollback) begin
                     state_d = IFETCH;
                     cnt_d   = 3'd0;
                     len_d   = FETCH_LEN;
                     base_d  = if_pc;
                     buf_d   = '0;
                  end
               end
            end
            IFETCH, LOAD: begin
               if (rollback) begin
                  state_d = IDLE;
                  cnt_d   = 3'd0;
               end else begin
                  if (cnt_q != 3'd0) begin
                     case (cnt_prev[1:0])
                        2'd0:    buf_d[7:0]   = mem_din;
                        2'd1:    buf_d[15:8]  = mem_din;
                        2'd2:    buf_d[23:16] = mem_din;
                        default: buf_d[31:24] = mem_din;
                     endcase
                  end
                  if (cnt_q == len_q) begin
                     state_d = IDLE;
                     cnt_d   = 3'd0;
                     if (state_q == IFETCH) begin
                        if_done_d = 1'b1;
                        if_data_d = buf_d;
                     end else begin
                        lsb_done_d   = 1'b1;
                        lsb_r_data_d = buf_d;
                     end
                  end else begin
                     cnt_d = cnt_q + 3'd1;
                  end
               end
            end
            STORE: begin
               if (!io_stall) begin
                  if (cnt_q == len_q - 3'd1) begin
                     state_d    = IDLE;
                     cnt_d      = 3'd0;
                     lsb_done_d = 1'b1;
                  end else begin
                     cnt_d = cnt_q + 3'd1;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= 3'd0;
         len_q        <= 3'd0;
         base_q       <= 32'd0;
         wdata_q      <= 32'd0;
         buf_q        <= 32'd0;
         if_done_q    <= 1'b0;
         lsb_done_q   <= 1'b0;
         if_data_q    <= 32'd0;
         lsb_r_data_q <= 32'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         len_q        <= len_d;
         base_q       <= base_d;
         wdata_q      <= wdata_d;
         buf_q        <= buf_d;
         if_done_q    <= if_done_d;
         lsb_done_q   <= lsb_done_d;
         if_data_q    <= if_data_d;
         lsb_r_data_q <= lsb_r_data_d;
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: expected writes and completion data are queued at stimulus time
// and checked as the controller produces them; directed checks cover cycle timing.
module tb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst, rdy, rollback;
   logic [7:0]  mem_din, mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr, io_buffer_full;
   logic        if_en;
   logic [31:0] if_pc;
   logic        if_done;
   logic [31:0] if_data;
   logic        lsb_en, lsb_wr;
   logic [31:0] lsb_addr;
   logic [2:0]  lsb_len;
   logic [31:0] lsb_w_data;
   logic        lsb_done;
   logic [31:0] lsb_r_data;

   mem_ctrl #(.FETCH_BYTES(4)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full),
      .if_en(if_en), .if_pc(if_pc), .if_done(if_done), .if_data(if_data),
      .lsb_en(lsb_en), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
      .lsb_w_data(lsb_w_data), .lsb_done(lsb_done), .lsb_r_data(lsb_r_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] ram [0:262143];
   always @(posedge clk) mem_din <= ram[mem_a[17:0]];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   logic [39:0] wr_q [$];
   logic [31:0] if_q [$];
   logic [32:0] ls_q [$];

   always @(negedge clk) begin : monitor
      logic [39:0] we;
      logic [31:0] ie;
      logic [32:0] le;
      if (!rst) begin
         if (mem_wr) begin
            we = (wr_q.size() != 0) ? wr_q.pop_front() : 40'hFF_FFFF_FFFF;
            chk("wr_addr", mem_a, we[39:8]);
            chk("wr_byte", {24'd0, mem_dout}, {24'd0, we[7:0]});
         end
         if (if_done) begin
            ie = (if_q.size() != 0) ? if_q.pop_front() : 32'hFFFF_FFFF;
            chk("if_data", if_data, ie);
         end
         if (lsb_done) begin
            le = (ls_q.size() != 0) ? ls_q.pop_front() : 33'h1_FFFF_FFFF;
            if (le[32]) chk("lsb_r_data", lsb_r_data, le[31:0]);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input bit lsb, input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (lsb ? lsb_done : if_done) begin
            at = cyc;
            break;
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic store_req(input logic [31:0] a, input logic [2:0] n, input logic [31:0] d);
      lsb_en = 1'b1; lsb_wr = 1'b1; lsb_addr = a; lsb_len = n; lsb_w_data = d;
      for (int i = 0; i < int'(n); i++) wr_q.push_back({a + 32'(i), d[8*i +: 8]});
      ls_q.push_back({1'b0, 32'd0});
   endtask

   int acc, acc2, at, at2, dcyc;
   logic [31:0] exp_v;

   initial begin
      for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
      ram[18'h00100] = 8'h13; ram[18'h00101] = 8'h05;
      ram[18'h00102] = 8'h00; ram[18'h00103] = 8'h00;
      ram[18'h02000] = 8'h80; ram[18'h02001] = 8'hFF;
      ram[18'h02002] = 8'h11; ram[18'h02003] = 8'h22;
      ram[18'h3FFFE] = 8'h11; ram[18'h3FFFF] = 8'h22;
      ram[18'h00000] = 8'h33; ram[18'h00001] = 8'h44;

      rst = 1'b1; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
      if_en = 1'b0; if_pc = 32'd0; lsb_en = 1'b0; lsb_wr = 1'b0;
      lsb_addr = 32'd0; lsb_len = 3'd0; lsb_w_data = 32'd0;
      step(); step();
      @(negedge clk);
      chk("rst_mem_wr", 32'(mem_wr), 32'd0);
      chk("rst_mem_a", mem_a, 32'd0);
      chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
      chk("rst_if_done", 32'(if_done), 32'd0);
      chk("rst_lsb_done", 32'(lsb_done), 32'd0);
      chk("rst_if_data", if_data, 32'd0);
      chk("rst_lsb_r_data", lsb_r_data, 32'd0);
      step(); rst = 1'b0;

      // fetch at 0x100, pc changed mid-flight must be ignored
      step(); if_en = 1'b1; if_pc = 32'h100; acc = cyc; if_q.push_back(32'h0000_0513);
      for (int k = 1; k <= 4; k++) begin
         step();
         if (k == 2) if_pc = 32'hDEAD_0000;
         @(negedge clk);
         chk($sformatf("fetch_a%0d", k), mem_a, 32'h100 + 32'(k - 1));
      end
      wait_done(1'b0, 10, at);
      chk("fetch_done_cyc", 32'(at - acc), 32'd6);
      step(); if_en = 1'b0;
      @(negedge clk);
      chk("if_done_pulse", 32'(if_done), 32'd0);

      // simultaneous requests: load wins, fetch follows after the done cycle
      step();
      if_en = 1'b1; if_pc = 32'h100; if_q.push_back(32'h0000_0513);
      lsb_en = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h2000; lsb_len = 3'd2; acc = cyc;
      ls_q.push_back({1'b1, 32'h0000_FF80});
      step(); @(negedge clk); chk("prio_a1", mem_a, 32'h2000);
      step(); @(negedge clk); chk("prio_a2", mem_a, 32'h2001);
      wait_done(1'b1, 8, at);
      chk("load_done_cyc", 32'(at - acc), 32'd4);
      step(); lsb_en = 1'b0;
      wait_done(1'b0, 12, at2);
      chk("fetch_after_load", 32'(at2 - at), 32'd7);
      step(); if_en = 1'b0;

      // store word, data/address changed after acceptance must be ignored
      step(); store_req(32'h3000, 3'd4, 32'hDEAD_BEEF); acc = cyc;
      step(); lsb_w_data = 32'h0; lsb_addr = 32'h5000;
      wait_done(1'b1, 10, at);
      chk("store_done_cyc", 32'(at - acc), 32'd5);
      step(); lsb_en = 1'b0;
      @(negedge clk);
      chk("store_no_reaccept", 32'(mem_wr), 32'd0);
      chk("lsb_done_pulse", 32'(lsb_done), 32'd0);

      // rollback aborts fetch; store accepted under rollback still completes
      step(); if_en = 1'b1; if_pc = 32'h100; acc = cyc;
      step(); step(); rollback = 1'b1;
      step(); if_en = 1'b0; store_req(32'h0, 3'd1, 32'h0000_005A); acc2 = cyc;
      step(); @(negedge clk);
      chk("rb_store_wr", 32'(mem_wr), 32'd1);
      chk("rb_store_a", mem_a, 32'h0);
      wait_done(1'b1, 6, at);
      chk("rb_store_done_cyc", 32'(at - acc2), 32'd2);
      step(); lsb_en = 1'b0; rollback = 1'b0;

      // load request coinciding with rollback is dropped
      step(); lsb_en = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h2000; lsb_len = 3'd1; rollback = 1'b1;
      step(); lsb_en = 1'b0; rollback = 1'b0;
      wait_done(1'b1, 6, at);
      chk("rb_load_suppressed", 32'(at), 32'hFFFF_FFFF);

      // IO store against a full buffer
      step(); store_req(32'h0003_0000, 3'd1, 32'h0000_0077); io_buffer_full = 1'b1; dcyc = -1;
      for (int k = 1; k <= 6; k++) begin
         step();
         if (dcyc == k - 1) lsb_en = 1'b0;
         if (k == 4) io_buffer_full = 1'b0;
         @(negedge clk);
`ifdef MEM_CTRL_IO_STALL_EN
         exp_v = (k == 4) ? 32'd1 : 32'd0;
`else
         exp_v = (k == 1) ? 32'd1 : 32'd0;
`endif
         if (k <= 4) chk($sformatf("io_wr_c%0d", k), 32'(mem_wr), exp_v);
         if (lsb_done) dcyc = k;
      end
`ifdef MEM_CTRL_IO_STALL_EN
      chk("io_done_cyc", 32'(dcyc), 32'd5);
`else
      chk("io_done_cyc", 32'(dcyc), 32'd2);
`endif

      // rdy low for two cycles in the middle of a word load
      step(); lsb_en = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h2000; lsb_len = 3'd4; acc = cyc;
      ls_q.push_back({1'b1, 32'h2211_FF80});
      step();
      step(); rdy = 1'b0;
      @(negedge clk); chk("frz_load_wr", 32'(mem_wr), 32'd0);
      step();
      step(); rdy = 1'b1;
      wait_done(1'b1, 10, at);
      chk("frz_load_done_cyc", 32'(at - acc), 32'd8);
      step(); lsb_en = 1'b0;

      // rdy low over the first byte of a halfword store
      step(); store_req(32'h3010, 3'd2, 32'h0000_BBAA); acc = cyc;
      step(); rdy = 1'b0;
      @(negedge clk); chk("frz_store_wr", 32'(mem_wr), 32'd0);
      step(); rdy = 1'b1;
      @(negedge clk); chk("frz_store_resume", 32'(mem_wr), 32'd1);
      wait_done(1'b1, 6, at);
      chk("frz_store_done_cyc", 32'(at - acc), 32'd4);
      step(); lsb_en = 1'b0;

      // fetch across the top of the address space
      step(); if_en = 1'b1; if_pc = 32'hFFFF_FFFE; acc = cyc; if_q.push_back(32'h4433_2211);
      for (int k = 1; k <= 4; k++) begin
         step(); @(negedge clk);
         chk($sformatf("wrap_a%0d", k), mem_a, 32'hFFFF_FFFE + 32'(k - 1));
      end
      wait_done(1'b0, 6, at);
      chk("wrap_done_cyc", 32'(at - acc), 32'd6);
      step(); if_en = 1'b0;

      // reset abandons an in-flight fetch, overriding rdy and rollback
      step(); if_en = 1'b1; if_pc = 32'h100;
      step(); step(); rst = 1'b1; rdy = 1'b0; rollback = 1'b1;
      step(); rst = 1'b0; rdy = 1'b1; rollback = 1'b0; if_en = 1'b0;
      @(negedge clk);
      chk("rst2_if_data", if_data, 32'd0);
      chk("rst2_lsb_r_data", lsb_r_data, 32'd0);
      chk("rst2_mem_a", mem_a, 32'd0);
      chk("rst2_mem_wr", 32'(mem_wr), 32'd0);
      wait_done(1'b0, 10, at);
      chk("rst2_no_done", 32'(at), 32'hFFFF_FFFF);

      chk("wr_q_left", 32'(wr_q.size()), 32'd0);
      chk("if_q_left", 32'(if_q.size()), 32'd0);
      chk("ls_q_left", 32'(ls_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 The block SHALL have parameter FETCH_BYTES, default 4, meaning bytes per instruction fetch (legal 1..4).
REQ-002 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 rdy  input  1  global enable; low SHALL freeze all state and force mem_wr=0.
REQ-005 rollback  input  1  misprediction flush.
REQ-006 mem_din  input  8  RAM read byte, valid the cycle after its address.
REQ-007 mem_dout  output  8  RAM write byte.
REQ-008 mem_a  output  32  RAM byte address.
REQ-009 mem_wr  output  1  1=write mem_dout to mem_a this cycle.
REQ-010 io_buffer_full  input  1  IO write buffer full.
REQ-011 if_en  input  1 / if_pc  input  32  instruction fetch request, held until if_done.
REQ-012 if_done  output  1 / if_data  output  32  fetch complete pulse; little-endian bytes, upper unused bytes zero.
REQ-013 lsb_en, lsb_wr  input  1 each / lsb_addr  input  32 / lsb_len  input  3 / lsb_w_data  input  32  data request (len 1, 2, 4), held until lsb_done.
REQ-014 lsb_done  output  1 / lsb_r_data  output  32  data complete pulse; load bytes zero-extended, little-endian.

Function
REQ-015 States SHALL be IDLE, IFETCH, LOAD, STORE; byte counter cnt counts 0..N, N = FETCH_BYTES or lsb_len.
REQ-016 In IDLE with if_done=0 and lsb_done=0, lsb_en SHALL be accepted before if_en; lsb_wr selects STORE or LOAD.
REQ-017 No request SHALL be accepted in a cycle where if_done or lsb_done is high.
REQ-018 Address, length, write data and pc SHALL be latched at acceptance; later input changes SHALL be ignored.
REQ-019 Read of N bytes: mem_a = base+k in cycle k+1 after acceptance, byte k sampled from mem_din in cycle k+2, done high exactly in cycle N+2.
REQ-020 Store of N bytes: mem_wr=1, mem_a=base+k, mem_dout = byte k of data in cycle k+1; lsb_done high exactly in cycle N+1.
REQ-021 Done outputs SHALL be one-cycle pulses; state SHALL be IDLE in the done cycle.
REQ-022 mem_wr SHALL be 0 in every cycle except store byte cycles.
REQ-023 Data outputs SHALL hold their value until the next completion.
REQ-024 rollback SHALL abort IFETCH and LOAD immediately (IDLE next cycle, no done pulse); STORE SHALL run to completion and pulse lsb_done.
REQ-025 rollback in the same cycle as an acceptance SHALL suppress it unless it is a store.
REQ-026 Address arithmetic SHALL wrap modulo 2^32.
REQ-027 An address is IO when bits [17:16] = 2'b11.

Reset
REQ-028 On rst: state IDLE, cnt 0, mem_wr 0, mem_a 0, mem_dout 0, if_done 0, lsb_done 0, if_data 0, lsb_r_data 0; rst SHALL override rdy and rollback, and SHALL abandon any in-flight access.

Configuration
REQ-029 With MEM_CTRL_IO_STALL_EN defined, a store byte to an IO address SHALL NOT be issued while io_buffer_full=1: mem_wr=0, cnt holds, and the store resumes the cycle after io_buffer_full falls.
REQ-030 Without MEM_CTRL_IO_STALL_EN, io_buffer_full SHALL be ignored.

Verification
REQ-031 Fetch: if_en=1, if_pc=0x100, RAM[0x100..0x103]=13,05,00,00 -> mem_a 0x100..0x103 in cycles 1-4; if_done in cycle 6; if_data=0x00000513.
REQ-032 Priority: if_en and lsb_en (load, len 2, 0x2000 holding 0x80,0xFF) rise together -> LOAD first, lsb_done cycle 4, lsb_r_data=0x0000FF80; IFETCH accepted after the done cycle.
REQ-033 Store: lsb_wr=1, len 4, addr 0x3000, data 0xDEADBEEF -> mem_wr=1 cycles 1-4, bytes EF,BE,AD,DE; lsb_done cycle 5; no re-accept while lsb_en is still high.
REQ-034 Rollback: rollback=1 during cycle 2 of a fetch -> no if_done, IDLE next cycle; rollback during cycle 2 of a store (len 1 at 0x0) -> write completes, lsb_done pulses.
REQ-035 IO stall (macro on): sb to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr stays 0 for those cycles, write issues the cycle after release; macro off -> write in cycle 1.
REQ-036 rdy=0 for 2 cycles mid-load -> mem_wr=0, counters frozen, done delayed by exactly 2 cycles, data correct.
